// File: rtl/cpu_types_pkg.sv
// Shared types for the cache-to-RAM memory controller: RAM handshake states,
// controller FSM encoding and a saturating counter helper.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef logic [1:0] memctl_state_t;

  localparam memctl_state_t IDLE   = 2'd0;
  localparam memctl_state_t DGRANT = 2'd1;
  localparam memctl_state_t IGRANT = 2'd2;
  localparam memctl_state_t ERR    = 2'd3;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mc_arbiter.sv
// Two-requester round-robin: a lone requester wins; on contention the side
// that did not win last time is granted. Purely combinational.
module mc_arbiter (
  input  logic dreq,
  input  logic ireq,
  input  logic last_d,
  output logic grant_d,
  output logic grant_i
);

  assign grant_d = dreq & (~ireq | ~last_d);
  assign grant_i = ireq & (~dreq |  last_d);

endmodule

// File: rtl/memory_control.sv
// Serialises icache fetches and dcache reads/writes onto one single-ported RAM.
// RAM strobes and wait/load outputs are combinational from the grant state and live inputs.
module memory_control
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              mem_error,
  output logic [31:0]       dtrans_cnt,
  output logic [31:0]       itrans_cnt
);

  localparam int BW = $clog2(TIMEOUT + 1);

  ramstate_t     rs;
  memctl_state_t state;
  memctl_state_t state_nxt;
  memctl_state_t arb_state;
  logic          last_d;
  logic [BW-1:0] busy_cnt;
  logic [BW-1:0] busy_nxt;
  logic          dreq;
  logic          ireq;
  logic          dgranted;
  logic          igranted;
  logic          ddone;
  logic          idone;
  logic          arb_last_d;
  logic          grant_d;
  logic          grant_i;

  assign rs       = ramstate_t'(ramstate);
  assign dreq     = dREN | dWEN;
  assign ireq     = iREN;
  assign dgranted = (state == DGRANT);
  assign igranted = (state == IGRANT);
  assign ddone    = dgranted & dreq & (rs == ACCESS);
  assign idone    = igranted & ireq & (rs == ACCESS);

  // On completion the side just served counts as the last grant, so the
  // back-to-back re-arbitration in the same cycle already alternates.
  assign arb_last_d = ddone ? 1'b1 : (idone ? 1'b0 : last_d);

  mc_arbiter u_arb (
    .dreq    (dreq),
    .ireq    (ireq),
    .last_d  (arb_last_d),
    .grant_d (grant_d),
    .grant_i (grant_i)
  );

  assign arb_state = grant_d ? DGRANT : (grant_i ? IGRANT : IDLE);

  always_comb begin
    state_nxt = state;
    busy_nxt  = '0;
    case (state)
      IDLE: state_nxt = arb_state;
      DGRANT, IGRANT: begin
        if (rs == ERROR) begin
          state_nxt = ERR;
        end else if (dgranted ? ~dreq : ~ireq) begin
          state_nxt = arb_state;
        end else if (rs == ACCESS) begin
          state_nxt = arb_state;
        end else if (busy_cnt == BW'(TIMEOUT - 1)) begin
          state_nxt = ERR;
        end else begin
          busy_nxt = busy_cnt + 1'b1;
        end
      end
      default: state_nxt = ERR;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      last_d     <= 1'b0;
      busy_cnt   <= '0;
      mem_error  <= 1'b0;
      dtrans_cnt <= 32'd0;
      itrans_cnt <= 32'd0;
    end else begin
      state    <= state_nxt;
      last_d   <= arb_last_d;
      busy_cnt <= busy_nxt;
      if (state_nxt == ERR) mem_error <= 1'b1;
      if (ddone) dtrans_cnt <= sat_inc(dtrans_cnt);
      if (idone) itrans_cnt <= sat_inc(itrans_cnt);
    end
  end

  always_comb begin
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      DGRANT: begin
        // A write wins when both strobes are up.
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = ~ddone;
        if (ddone && !dWEN) dload = ramload;
      end
      IGRANT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        iwait   = ~idone;
        if (idone) iload = ramload;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_memory_control.sv
// Directed scenarios plus a randomized run against a transaction-level model of the controller.
module tb_memory_control;

  localparam int TIMEOUT = 64;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        mem_error;
  logic [31:0] dtrans_cnt;
  logic [31:0] itrans_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  memory_control #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .mem_error(mem_error), .dtrans_cnt(dtrans_cnt), .itrans_cnt(itrans_cnt)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = 2'd0;
  endtask

  task automatic do_reset();
    RST = 1;
    idle_inputs();
    tick();
    RST = 0;
  endtask

  task automatic test_reset();
    RST = 1;
    iREN = 1; dREN = 1; dWEN = 1; iaddr = 32'h44; daddr = 32'h88; dstore = 32'h99;
    ramload = 32'hCAFE_F00D; ramstate = 2'd2;
    tick();
    #1;
    n_cmp++;
    if ({iwait, dwait, ramREN, ramWEN, mem_error} !== 5'b11000) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 11000", {iwait, dwait, ramREN, ramWEN, mem_error});
    end
    n_cmp++;
    if ({iload, dload, ramaddr, ramstore} !== 128'd0) begin
      n_bad++;
      $display("FAIL reset_data: got iload=%h dload=%h ramaddr=%h ramstore=%h want 0",
               iload, dload, ramaddr, ramstore);
    end
    n_cmp++;
    if ({dtrans_cnt, itrans_cnt} !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_cnt: got d=%0d i=%0d want 0/0", dtrans_cnt, itrans_cnt);
    end
    RST = 0;
    idle_inputs();
  endtask

  task automatic test_dcache_read();
    do_reset();
    dREN = 1; daddr = 32'h100;
    tick();
    ramstate = 2'd1;
    #1;
    n_cmp++;
    if ({ramREN, ramWEN, dwait, iwait} !== 4'b1011 || ramaddr !== 32'h100) begin
      n_bad++;
      $display("FAIL dread_grant: got strobes/waits=%b addr=%h want 1011 addr=100",
               {ramREN, ramWEN, dwait, iwait}, ramaddr);
    end
    tick();
    tick();
    ramstate = 2'd2; ramload = 32'hDEAD_BEEF;
    #1;
    n_cmp++;
    if (dwait !== 1'b0 || dload !== 32'hDEAD_BEEF || iwait !== 1'b1) begin
      n_bad++;
      $display("FAIL dread_done: got dwait=%b dload=%h iwait=%b want 0 deadbeef 1", dwait, dload, iwait);
    end
    tick();
    dREN = 0; ramstate = 2'd0;
    #1;
    n_cmp++;
    if (dwait !== 1'b1 || ramREN !== 1'b0 || dtrans_cnt !== 32'd1 || itrans_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL dread_after: got dwait=%b ramREN=%b dcnt=%0d icnt=%0d want 1 0 1 0",
               dwait, ramREN, dtrans_cnt, itrans_cnt);
    end
  endtask

  task automatic test_contention();
    do_reset();
    iREN = 1; iaddr = 32'h0;
    dWEN = 1; daddr = 32'h3100; dstore = 32'h5;
    tick();
    ramstate = 2'd2;
    #1;
    n_cmp++;
    if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'h5 || ramaddr !== 32'h3100 ||
        dwait !== 1'b0 || dload !== 32'd0 || iwait !== 1'b1) begin
      n_bad++;
      $display("FAIL cont_dfirst: got WEN=%b REN=%b store=%h addr=%h dwait=%b dload=%h iwait=%b",
               ramWEN, ramREN, ramstore, ramaddr, dwait, dload, iwait);
    end
    tick();
    dWEN = 0; ramload = 32'h1234_5678;
    #1;
    n_cmp++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h0 || iwait !== 1'b0 || iload !== 32'h1234_5678 ||
        dwait !== 1'b1) begin
      n_bad++;
      $display("FAIL cont_inext: got REN=%b addr=%h iwait=%b iload=%h dwait=%b want 1 0 0 12345678 1",
               ramREN, ramaddr, iwait, iload, dwait);
    end
    tick();
    iREN = 0; ramstate = 2'd0;
    #1;
    n_cmp++;
    if (dtrans_cnt !== 32'd1 || itrans_cnt !== 32'd1) begin
      n_bad++;
      $display("FAIL cont_cnt: got d=%0d i=%0d want 1/1", dtrans_cnt, itrans_cnt);
    end
  endtask

  task automatic test_back_to_back();
    bit exp_last_d;
    bit exp_d;
    do_reset();
    iREN = 1; dREN = 1; iaddr = 32'h40; daddr = 32'h80; ramstate = 2'd2;
    tick();
    exp_last_d = 0;
    for (int i = 0; i < 6; i++) begin
      exp_d = ~exp_last_d;
      ramload = $urandom;
      #1;
      n_cmp++;
      if ({dwait, iwait} !== (exp_d ? 2'b01 : 2'b10)) begin
        n_bad++;
        $display("FAIL b2b_grant%0d: got dwait/iwait=%b want %b", i, {dwait, iwait},
                 exp_d ? 2'b01 : 2'b10);
      end
      exp_last_d = exp_d;
      tick();
    end
    iREN = 0; dREN = 0; ramstate = 2'd0;
    #1;
    n_cmp++;
    if (dtrans_cnt !== 32'd3 || itrans_cnt !== 32'd3) begin
      n_bad++;
      $display("FAIL b2b_cnt: got d=%0d i=%0d want 3/3", dtrans_cnt, itrans_cnt);
    end
  endtask

  task automatic test_withdraw();
    do_reset();
    dREN = 1; daddr = 32'h200;
    tick();
    ramstate = 2'd1;
    #1;
    n_cmp++;
    if (ramREN !== 1'b1) begin
      n_bad++;
      $display("FAIL wd_grant: got ramREN=%b want 1", ramREN);
    end
    tick();
    dREN = 0;
    #1;
    n_cmp++;
    if (ramREN !== 1'b0 || dwait !== 1'b1) begin
      n_bad++;
      $display("FAIL wd_drop: got ramREN=%b dwait=%b want 0 1", ramREN, dwait);
    end
    tick();
    // Re-raising the request here only shows on the RAM if a grant were still held.
    dREN = 1; ramstate = 2'd2;
    #1;
    n_cmp++;
    if (ramREN !== 1'b0 || dwait !== 1'b1 || dtrans_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL wd_idle: got ramREN=%b dwait=%b dcnt=%0d want 0 1 0", ramREN, dwait, dtrans_cnt);
    end
    dREN = 0; ramstate = 2'd0;
  endtask

  task automatic test_timeout();
    do_reset();
    dWEN = 1; iREN = 1; iaddr = 32'h44;
    tick();
    ramstate = 2'd2;
    tick();
    dWEN = 0; ramstate = 2'd1;
    for (int k = 0; k < TIMEOUT; k++) begin
      #1;
      n_cmp++;
      if (ramREN !== 1'b1 || mem_error !== 1'b0) begin
        n_bad++;
        $display("FAIL to_busy%0d: got ramREN=%b mem_error=%b want 1 0", k, ramREN, mem_error);
      end
      tick();
    end
    #1;
    n_cmp++;
    if (mem_error !== 1'b1 || {ramREN, ramWEN, iwait, dwait} !== 4'b0011) begin
      n_bad++;
      $display("FAIL to_err: got mem_error=%b strobes/waits=%b want 1 0011",
               mem_error, {ramREN, ramWEN, iwait, dwait});
    end
    ramstate = 2'd2; dWEN = 1;
    tick();
    #1;
    n_cmp++;
    if (mem_error !== 1'b1 || {ramREN, ramWEN, iwait, dwait} !== 4'b0011) begin
      n_bad++;
      $display("FAIL to_sticky: got mem_error=%b strobes/waits=%b want 1 0011",
               mem_error, {ramREN, ramWEN, iwait, dwait});
    end
    n_cmp++;
    if (dtrans_cnt !== 32'd1) begin
      n_bad++;
      $display("FAIL to_precnt: got dcnt=%0d want 1", dtrans_cnt);
    end
    RST = 1;
    tick();
    RST = 0;
    idle_inputs();
    #1;
    n_cmp++;
    if (mem_error !== 1'b0 || dtrans_cnt !== 32'd0 || itrans_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL to_reset: got mem_error=%b d=%0d i=%0d want 0 0 0", mem_error, dtrans_cnt, itrans_cnt);
    end
  endtask

  task automatic test_ram_error();
    do_reset();
    dWEN = 1; daddr = 32'h8;
    tick();
    ramstate = 2'd3;
    #1;
    n_cmp++;
    if (mem_error !== 1'b0 || ramWEN !== 1'b1) begin
      n_bad++;
      $display("FAIL rerr_pre: got mem_error=%b ramWEN=%b want 0 1", mem_error, ramWEN);
    end
    tick();
    ramstate = 2'd0;
    #1;
    n_cmp++;
    if (mem_error !== 1'b1 || ramWEN !== 1'b0 || dwait !== 1'b1) begin
      n_bad++;
      $display("FAIL rerr_post: got mem_error=%b ramWEN=%b dwait=%b want 1 0 1", mem_error, ramWEN, dwait);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    iREN = 1; iaddr = 32'h10;
    tick();
    ramstate = 2'd1;
    #1;
    n_cmp++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h10) begin
      n_bad++;
      $display("FAIL rmid_grant: got ramREN=%b addr=%h want 1 10", ramREN, ramaddr);
    end
    RST = 1;
    tick();
    RST = 0;
    ramstate = 2'd2; ramload = $urandom;
    #1;
    n_cmp++;
    if ({iwait, dwait, ramREN, ramWEN} !== 4'b1100 || iload !== 32'd0 || ramaddr !== 32'd0 ||
        itrans_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL rmid_after: got waits/strobes=%b iload=%h addr=%h icnt=%0d want 1100 0 0 0",
               {iwait, dwait, ramREN, ramWEN}, iload, ramaddr, itrans_cnt);
    end
  endtask

  function automatic int pick(bit dq, bit iq, bit last_was_d);
    if (dq && iq) return last_was_d ? 2 : 1;
    if (dq) return 1;
    if (iq) return 2;
    return 0;
  endfunction

  // Model: owner 0=none, 1=dcache, 2=icache, 3=error; busy_run counts waiting cycles of one grant.
  task automatic test_random();
    int          owner, busy_run, stuck, p;
    bit          last_was_d, m_err, dq, req, done, r_i, r_d, r_w;
    logic [31:0] m_dcnt, m_icnt, e_addr, e_store, e_iload, e_dload;
    logic [3:0]  e_ctl;
    do_reset();
    owner = 0; busy_run = 0; last_was_d = 0; m_err = 0; m_dcnt = 0; m_icnt = 0;
    r_i = 0; r_d = 0; r_w = 0; stuck = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (stuck == 0) begin
        if ($urandom_range(3) == 0) r_i = ~r_i;
        if ($urandom_range(3) == 0) r_d = ~r_d;
        if ($urandom_range(5) == 0) r_w = ~r_w;
      end
      iREN = r_i; dREN = r_d; dWEN = r_w;
      iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
      if (stuck > 0) begin
        ramstate = 2'd1;
        stuck--;
      end else if ($urandom_range(399) == 0) begin
        ramstate = 2'd1;
        stuck = 70;
      end else begin
        p = $urandom_range(199);
        ramstate = (p == 0) ? 2'd3 : (p < 30) ? 2'd0 : (p < 120) ? 2'd1 : 2'd2;
      end
      RST = (m_err && $urandom_range(3) == 0) || ($urandom_range(499) == 0);
      #1;
      dq = dREN | dWEN;
      req = (owner == 1) ? dq : (owner == 2) ? iREN : 1'b0;
      done = req && (ramstate == 2'd2);
      e_ctl = 4'b1100; e_addr = 0; e_store = 0; e_iload = 0; e_dload = 0;
      if (owner == 1) begin
        e_ctl = {1'b1, ~done, dREN & ~dWEN, dWEN};
        e_addr = daddr; e_store = dstore;
        if (done && !dWEN) e_dload = ramload;
      end else if (owner == 2) begin
        e_ctl = {~done, 1'b1, 1'b1, 1'b0};
        e_addr = iaddr;
        if (done) e_iload = ramload;
      end
      n_cmp++;
      if ({iwait, dwait, ramREN, ramWEN} !== e_ctl) begin
        n_bad++;
        $display("FAIL rnd_ctl cyc%0d: got %b want %b", cyc, {iwait, dwait, ramREN, ramWEN}, e_ctl);
      end
      n_cmp++;
      if (ramaddr !== e_addr || ramstore !== e_store) begin
        n_bad++;
        $display("FAIL rnd_ram cyc%0d: got addr=%h store=%h want %h %h", cyc, ramaddr, ramstore, e_addr, e_store);
      end
      n_cmp++;
      if (iload !== e_iload || dload !== e_dload) begin
        n_bad++;
        $display("FAIL rnd_load cyc%0d: got i=%h d=%h want %h %h", cyc, iload, dload, e_iload, e_dload);
      end
      n_cmp++;
      if (mem_error !== m_err || dtrans_cnt !== m_dcnt || itrans_cnt !== m_icnt) begin
        n_bad++;
        $display("FAIL rnd_stat cyc%0d: got err=%b d=%0d i=%0d want %b %0d %0d",
                 cyc, mem_error, dtrans_cnt, itrans_cnt, m_err, m_dcnt, m_icnt);
      end
      if (RST) begin
        owner = 0; busy_run = 0; last_was_d = 0; m_err = 0; m_dcnt = 0; m_icnt = 0;
      end else if (owner == 0) begin
        owner = pick(dq, iREN, last_was_d);
      end else if (owner != 3) begin
        if (ramstate == 2'd3) begin
          owner = 3; m_err = 1;
        end else if (!req) begin
          owner = pick(dq, iREN, last_was_d); busy_run = 0;
        end else if (done) begin
          if (owner == 1) begin
            if (m_dcnt != 32'hFFFF_FFFF) m_dcnt++;
            last_was_d = 1;
          end else begin
            if (m_icnt != 32'hFFFF_FFFF) m_icnt++;
            last_was_d = 0;
          end
          owner = pick(dq, iREN, last_was_d); busy_run = 0;
        end else begin
          busy_run++;
          if (busy_run >= TIMEOUT) begin
            owner = 3; m_err = 1;
          end
        end
      end
      tick();
    end
    RST = 0;
    idle_inputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RST = 1;
    idle_inputs();
    test_reset();
    test_dcache_read();
    test_contention();
    test_back_to_back();
    test_withdraw();
    test_timeout();
    test_ram_error();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
